// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encoding for the comparator run tracker
package cmp_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/cmp_mag.sv
// rtl/cmp_mag.sv - unsigned magnitude compare, exactly one of gt/eq/lt high
module cmp_mag #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_run_tracker.sv
// rtl/cmp_run_tracker.sv - per-frame running max/min and rise/equal/fall counts
module cmp_run_tracker
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out,
    output logic [CW-1:0]    gt_cnt,
    output logic [CW-1:0]    eq_cnt,
    output logic [CW-1:0]    lt_cnt
);

    state_t           state, state_nx;
    logic [CW-1:0]    remaining;
    logic [WIDTH-1:0] prev;
    logic             first;
    logic             hs;
    logic             p_gt, p_eq, p_lt;
    logic             mx_gt, mx_eq, mx_lt;
    logic             mn_gt, mn_eq, mn_lt;
    logic             unused_cmp;

    cmp_mag #(.WIDTH(WIDTH)) u_vs_prev (.a(in_data), .b(prev),    .gt(p_gt),  .eq(p_eq),  .lt(p_lt));
    cmp_mag #(.WIDTH(WIDTH)) u_vs_max  (.a(in_data), .b(max_out), .gt(mx_gt), .eq(mx_eq), .lt(mx_lt));
    cmp_mag #(.WIDTH(WIDTH)) u_vs_min  (.a(in_data), .b(min_out), .gt(mn_gt), .eq(mn_eq), .lt(mn_lt));

    assign unused_cmp = &{1'b0, mx_eq, mx_lt, mn_gt, mn_eq};

    assign in_ready = (state == ST_RUN);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign hs       = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = (len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (hs && remaining == CW'(1)) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Results are only cleared by an accepted start, so they hold through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            prev      <= '0;
            first     <= 1'b0;
            max_out   <= '0;
            min_out   <= '0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            lt_cnt    <= '0;
        end else if (state == ST_IDLE && start) begin
            remaining <= len;
            prev      <= '0;
            first     <= (len != '0);
            max_out   <= '0;
            min_out   <= '0;
            gt_cnt    <= '0;
            eq_cnt    <= '0;
            lt_cnt    <= '0;
        end else if (hs) begin
            remaining <= remaining - 1'b1;
            prev      <= in_data;
            if (first) begin
                // The first sample seeds the extremes and has no predecessor to compare.
                first   <= 1'b0;
                max_out <= in_data;
                min_out <= in_data;
            end else begin
                if (p_gt) gt_cnt <= gt_cnt + 1'b1;
                if (p_eq) eq_cnt <= eq_cnt + 1'b1;
                if (p_lt) lt_cnt <= lt_cnt + 1'b1;
                if (mx_gt) max_out <= in_data;
                if (mn_lt) min_out <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_cmp_run_tracker.sv
// tb/tb_cmp_run_tracker.sv - directed and randomized frames against a queue-based reference
module tb_cmp_run_tracker;

    localparam int WIDTH = 4;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CW-1:0]    len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] max_out;
    logic [WIDTH-1:0] min_out;
    logic [CW-1:0]    gt_cnt;
    logic [CW-1:0]    eq_cnt;
    logic [CW-1:0]    lt_cnt;

    int total = 0;
    int bad   = 0;

    cmp_run_tracker #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done), .max_out(max_out), .min_out(min_out),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_results(input string tag, input int e_max, input int e_min,
                               input int e_gt, input int e_eq, input int e_lt);
        chk({tag, ".max"}, 32'(max_out), 32'(e_max));
        chk({tag, ".min"}, 32'(min_out), 32'(e_min));
        chk({tag, ".gt"},  32'(gt_cnt),  32'(e_gt));
        chk({tag, ".eq"},  32'(eq_cnt),  32'(e_eq));
        chk({tag, ".lt"},  32'(lt_cnt),  32'(e_lt));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk_results(tag, 0, 0, 0, 0, 0);
    endtask

    // Reference: results of a frame computed directly from the sample list.
    task automatic model(input int s[$], output int e_max, output int e_min,
                         output int e_gt, output int e_eq, output int e_lt);
        e_max = 0; e_min = 0; e_gt = 0; e_eq = 0; e_lt = 0;
        if (s.size() > 0) begin
            e_max = s[0];
            e_min = s[0];
        end
        for (int i = 1; i < s.size(); i++) begin
            if (s[i] > s[i-1]) e_gt++;
            else if (s[i] == s[i-1]) e_eq++;
            else e_lt++;
            if (s[i] > e_max) e_max = s[i];
            if (s[i] < e_min) e_min = s[i];
        end
    endtask

    // Runs one frame; called at posedge+1 with the DUT idle. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input string tag, input int s[$], input int max_bubble,
                             input bit hold_start, input int abort_at);
        int e_max, e_min, e_gt, e_eq, e_lt;
        int n;
        n = s.size();
        model(s, e_max, e_min, e_gt, e_eq, e_lt);
        start = 1'b1;
        len   = CW'(n);
        @(posedge clk); #1;
        start = hold_start;
        len   = CW'($urandom);
        if (n == 0) begin
            @(negedge clk);
            chk({tag, ".done0"},  32'(done),     32'd1);
            chk({tag, ".ready0"}, 32'(in_ready), 32'd0);
            chk_results(tag, 0, 0, 0, 0, 0);
            start = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".done_off"}, 32'(done),     32'd0);
            chk({tag, ".ready1"},   32'(in_ready), 32'd0);
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                in_valid = 1'b0;
                #2 rst = 1'b1;
                #1 chk_reset_state({tag, ".abort"});
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            for (int b = 0; b < $urandom_range(max_bubble, 0); b++) begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                @(negedge clk);
                chk({tag, ".bub_ready"}, 32'(in_ready), 32'd1);
                chk({tag, ".bub_done"},  32'(done),     32'd0);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(s[i]);
            @(negedge clk);
            chk({tag, ".ready"}, 32'(in_ready), 32'd1);
            chk({tag, ".nodone"}, 32'(done),    32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        @(negedge clk);
        chk({tag, ".done"},       32'(done),     32'd1);
        chk({tag, ".done_ready"}, 32'(in_ready), 32'd0);
        chk_results(tag, e_max, e_min, e_gt, e_eq, e_lt);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ".post_done"}, 32'(done), 32'd0);
            chk({tag, ".post_busy"}, 32'(busy), 32'd0);
        end
        chk_results({tag, ".hold"}, e_max, e_min, e_gt, e_eq, e_lt);
        @(posedge clk); #1;
    endtask

    initial begin
        int s[$];
        int n;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
        #1 chk_reset_state("init");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        s = '{2, 3, 6, 5};
        run_frame("t2", s, 0, 1'b0, -1);

        // Async reset with nonzero results held: outputs must clear before any clock edge.
        #2 rst = 1'b1;
        #1 chk_reset_state("t1");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int r = 0; r < 3; r++) run_frame("t3", s, 3, 1'b0, -1);

        s = '{7, 7, 7};
        run_frame("t4", s, 1, 1'b1, -1);

        s = {};
        run_frame("t5", s, 0, 1'b0, -1);

        s = '{1, 9, 4, 12, 3};
        run_frame("t6a", s, 1, 1'b0, 2);
        s = '{15, 0};
        run_frame("t6b", s, 0, 1'b0, -1);

        for (int r = 0; r < 20; r++) begin
            s = {};
            n = $urandom_range(12, 1);
            for (int i = 0; i < n; i++) s.push_back(int'($urandom_range(15, 0)));
            run_frame("rnd", s, $urandom_range(2, 0), bit'($urandom_range(1, 0)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
